// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller. It owns the architectural HI/LO registers.
// Latency: Busy stays high MULT_CYCLES/DIV_CYCLES cycles after acceptance. HI/LO update as Busy falls. MTHI/MTLO take one cycle.
// Backpressure: Start is ignored while Busy=1. Cancel aborts an in-flight op. Defining MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [3:0]    op_q;
`ifdef MDU_MADD_EN
  logic [63:0]   acc_q;
`endif

  logic               is_mul;
  logic               is_div;
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic [63:0]        a_zx;
  logic [63:0]        b_zx;
  logic [63:0]        prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        div_b;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic [31:0]        div_q;
  logic [31:0]        div_r;
  logic [63:0]        res;

  // Decode which opcodes start a multi-cycle multiply or divide.
  always_comb begin
    is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (MDUOp == OP_MADD) || (MDUOp == OP_MADDU) ||
             (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
`endif
    is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  end

  // Signed and unsigned full-width products of the latched operands.
  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign a_zx   = {32'h0, a_q};
  assign b_zx   = {32'h0, b_q};
  assign prod_u = a_zx * b_zx;

  // The divide runs on magnitudes, so the most-negative dividend needs no overflow special case.
  // The quotient takes the XOR of the operand signs and the remainder takes the dividend sign.
  assign a_neg = (op_q == OP_DIV) && a_q[31];
  assign b_neg = (op_q == OP_DIV) && b_q[31];
  assign a_mag = a_neg ? (32'h0 - a_q) : a_q;
  assign b_mag = b_neg ? (32'h0 - b_q) : b_q;
  assign div_b = (b_q == 32'h0) ? 32'h1 : b_mag;
  assign uq    = a_mag / div_b;
  assign ur    = a_mag % div_b;
  assign div_q = (a_neg ^ b_neg) ? (32'h0 - uq) : uq;
  assign div_r = a_neg ? (32'h0 - ur) : ur;

  // Select the {HI,LO} value that is written on the last busy cycle.
  always_comb begin
    res = prod_u;
    case (op_q)
      OP_MULT:          res = prod_s;
      OP_MULTU:         res = prod_u;
      OP_DIV, OP_DIVU:  res = (b_q == 32'h0) ? {a_q, 32'hFFFF_FFFF} : {div_r, div_q};
`ifdef MDU_MADD_EN
      OP_MADD:          res = acc_q + prod_s;
      OP_MADDU:         res = acc_q + prod_u;
      OP_MSUB:          res = acc_q - prod_s;
      OP_MSUBU:         res = acc_q - prod_u;
`endif
      default:          res = prod_u;
    endcase
  end

  // Control FSM: accepts ops, counts the busy window, and writes HI/LO. Cancel does not stop the final write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= 32'h0;
      LO    <= 32'h0;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      op_q  <= 4'h0;
`ifdef MDU_MADD_EN
      acc_q <= 64'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Cancel) begin
            if (is_mul) begin
              state <= MUL;
              cnt   <= CW'(MULT_CYCLES);
              Busy  <= 1'b1;
              a_q   <= A;
              b_q   <= B;
              op_q  <= MDUOp;
`ifdef MDU_MADD_EN
              acc_q <= {HI, LO};
`endif
            end else if (is_div) begin
              state <= DIV;
              cnt   <= CW'(DIV_CYCLES);
              Busy  <= 1'b1;
              a_q   <= A;
              b_q   <= B;
              op_q  <= MDUOp;
            end else if (MDUOp == OP_MTHI) begin
              HI <= A;
            end else if (MDUOp == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        MUL, DIV: begin
          if (cnt == CW'(1)) begin
            HI    <= res[63:32];
            LO    <= res[31:0];
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else if (Cancel) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl. A reference model predicts Busy/HI/LO from the op rules, and every cycle is checked.
// The model computes each result arithmetically at issue time and releases it after the op's latency.
// Literal checks pin the hand-computed cases.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic        Cancel = 1'b0;
  logic [3:0]  MDUOp = 4'h0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference state: architectural HI/LO, busy cycles still to run, and the pending result.
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  int          m_rem = 0;
  logic [63:0] m_res = 64'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic signed [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] zx(input logic [31:0] v);
    return {32'h0, v};
  endfunction

  // Returns {remainder, quotient} using 64-bit arithmetic, which truncates toward zero.
  function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic [63:0]        uq;
    logic [63:0]        ur;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    if (sgn) begin
      q = sx(a) / sx(b);
      r = sx(a) % sx(b);
      return {r[31:0], q[31:0]};
    end
    uq = zx(a) / zx(b);
    ur = zx(a) % zx(b);
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic model_step(input logic rs, input logic st, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic cn);
    logic [63:0] acc;
    acc = {m_hi, m_lo};
    if (!rs) begin
      m_hi = 32'h0; m_lo = 32'h0; m_rem = 0;
    end else if (m_rem > 0) begin
      if (m_rem == 1) begin
        m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_rem = 0;
      end else if (cn) m_rem = 0;
      else m_rem--;
    end else if (st && !cn) begin
      case (op)
        4'd1: begin m_res = sx(a) * sx(b); m_rem = MC; end
        4'd2: begin m_res = zx(a) * zx(b); m_rem = MC; end
        4'd3: begin m_res = div_ref(1'b1, a, b); m_rem = DC; end
        4'd4: begin m_res = div_ref(1'b0, a, b); m_rem = DC; end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
`ifdef MDU_MADD_EN
        4'd7:  begin m_res = acc + sx(a) * sx(b); m_rem = MC; end
        4'd8:  begin m_res = acc + zx(a) * zx(b); m_rem = MC; end
        4'd9:  begin m_res = acc - sx(a) * sx(b); m_rem = MC; end
        4'd10: begin m_res = acc - zx(a) * zx(b); m_rem = MC; end
`endif
        default: ;
      endcase
    end
  endtask

  // Compare the DUT against the model on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'h0, Busy}, (m_rem > 0) ? 32'h1 : 32'h0);
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
    end
  end

  task automatic cyc(input logic st, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic cn, input logic rs);
    Start = st; MDUOp = op; A = a; B = b; Cancel = cn; reset = rs;
    @(posedge clk);
    model_step(rs, st, op, a, b, cn);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    cyc(1'b1, op, a, b, 1'b0, 1'b1);
  endtask

  // Counts the busy cycles still to run. The bound keeps a hung DUT from stalling the bench.
  task automatic wait_done(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      idle(1);
    end
  endtask

  int nb;

  initial begin
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'd1, 32'h5, 32'h5, 1'b1, 1'b0);
    chk_en = 1'b1;
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);

    issue(4'd0, 32'h11, 32'h22);
    issue(4'd12, 32'h11, 32'h22);
    issue(4'd5, 32'h1234, 32'h0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_busy", {31'h0, Busy}, 32'h0);

    issue(4'd1, 32'hFFFF_FFFE, 32'h3);
    wait_done(nb);
    chk("mult_cycles", nb, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    issue(4'd3, 32'hFFFF_FFF9, 32'h2);
    wait_done(nb);
    chk("div_cycles", nb, 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    issue(4'd4, 32'h5, 32'h0);
    wait_done(nb);
    chk("divz_lo", LO, 32'hFFFF_FFFF);
    chk("divz_hi", HI, 32'h5);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb);
    chk("divov_lo", LO, 32'h8000_0000);
    chk("divov_hi", HI, 32'h0);

    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h1);

    issue(4'd3, 32'd100, 32'd7);
    idle(2);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("cancel_busy", {31'h0, Busy}, 32'h0);
    chk("cancel_hi", HI, 32'hFFFF_FFFE);
    chk("cancel_lo", LO, 32'h1);

    cyc(1'b1, 4'd5, 32'hDEAD, 32'h0, 1'b1, 1'b1);
    chk("stcan_hi", HI, 32'hFFFF_FFFE);
    cyc(1'b1, 4'd1, 32'h7, 32'h7, 1'b1, 1'b1);
    chk("stcan_busy", {31'h0, Busy}, 32'h0);
    issue(4'd6, 32'h55, 32'h0);
    chk("idle_mtlo", LO, 32'h55);

    issue(4'd1, 32'd6, 32'd7);
    idle(1);
    issue(4'd6, 32'h1, 32'h0);
    wait_done(nb);
    chk("busy_ign_lo", LO, 32'd42);
    chk("busy_ign_hi", HI, 32'h0);

    issue(4'd1, 32'd3, 32'd4);
    wait_done(nb);
    chk("b2b_first", LO, 32'd12);
    issue(4'd1, 32'd5, 32'd5);
    chk("b2b_accept", {31'h0, Busy}, 32'h1);
    wait_done(nb);
    chk("b2b_cycles", nb, 32'd5);
    chk("b2b_lo", LO, 32'd25);

    issue(4'd1, 32'd2, 32'd2);
    idle(4);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("lastcan_lo", LO, 32'd4);

    issue(4'd4, 32'hFFFF_FFFF, 32'd10);
    wait_done(nb);
    issue(4'd3, 32'd100, 32'hFFFF_FFFD);
    wait_done(nb);

    issue(4'd3, 32'd100, 32'd3);
    idle(3);
    cyc(1'b1, 4'd5, 32'h99, 32'h0, 1'b1, 1'b0);
    chk("rstmid_busy", {31'h0, Busy}, 32'h0);
    chk("rstmid_hi", HI, 32'h0);
    chk("rstmid_lo", LO, 32'h0);

    issue(4'd6, 32'hFFFF_FFFF, 32'h0);
    issue(4'd8, 32'h1, 32'h1);
    wait_done(nb);
`ifdef MDU_MADD_EN
    chk("maddu_cycles", nb, 32'd5);
    chk("maddu_hi", HI, 32'h1);
    chk("maddu_lo", LO, 32'h0);
`else
    chk("maddu_cycles", nb, 32'd0);
    chk("maddu_hi", HI, 32'h0);
    chk("maddu_lo", LO, 32'hFFFF_FFFF);
`endif
    issue(4'd9, 32'h2, 32'hFFFF_FFFD);
    wait_done(nb);
    issue(4'd10, 32'h3, 32'h4);
    wait_done(nb);
    issue(4'd7, 32'h8000_0000, 32'h2);
    wait_done(nb);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
